pipeline_chain: RTL and testbench
=================================

Name: pipeline_chain

Overview:
- Parametrised in-order pipeline register chain: DEPTH stages of a WIDTH-bit payload, each with a valid bit.
- Replaces the fixed per-boundary stage registers (fetch/decode, decode/execute, execute/memory, memory/writeback) with one generic block.
- Per-stage stall and flush; automatic bubble insertion behind a stall; saturating performance counters.
- Sits between the hazard unit (stall/flush sources) and stage datapaths; also carries the per-stage instruction-trace text in benches.

Parameters:
- WIDTH, 32, payload bits per stage.
- DEPTH, 4, number of stages (≥2); stage 0 is youngest, stage DEPTH-1 is oldest.
- CLEAR_DATA, 1, 1: a bubbled or flushed stage loads all-zero payload; 0: payload holds its old value and only valid clears.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  new entry presented to stage 0.
- in_data  in  WIDTH  payload for stage 0.
- in_ready  out  1  stage 0 accepts this cycle; equals ~hold[0].
- stall  in  DEPTH  stall[k] freezes stage k and all younger stages.
- flush  in  DEPTH  flush[k] invalidates stage k at the next edge.
- stage_valid  out  DEPTH  valid bit of each stage.
- stage_data  out  DEPTH*WIDTH  stage k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  = stage_valid[DEPTH-1].
- out_data  out  WIDTH  = payload of stage DEPTH-1.
- retire  out  1  = out_valid & ~stall[DEPTH-1] & ~flush[DEPTH-1] (combinational).
- cnt_retired  out  CNT_W  retire pulses counted.
- cnt_stall  out  CNT_W  cycles with hold[0]=1.
- cnt_bubble  out  CNT_W  bubbles inserted: stages k≥1 with hold[k-1] & ~hold[k], plus flushes of valid stages.

Behaviour:
- hold[k] = OR of stall[j] for j = k..DEPTH-1 (combinational).
- Per stage k at each rising edge, highest priority first:
  1. reset: valid←0, data←0.
  2. flush[k]: valid←0; data←0 if CLEAR_DATA. Flush overrides hold.
  3. hold[k]: valid and data keep.
  4. k>0 and hold[k-1]: bubble, valid←0; data←0 if CLEAR_DATA.
  5. Otherwise: k=0 loads in_valid/in_data; k>0 loads stage k-1.
- Latency: an entry accepted at edge t appears at out_valid after edge t+DEPTH-1 when there are no stalls.
- in_data is captured even when in_valid=0; the valid bit qualifies it.
- Stall and flush on the same stage in the same cycle: flush wins. The stage empties while the younger stages stay frozen. This is the load-use case (stall decode, flush execute).
- Stall of the oldest stage: the whole chain freezes; retire=0.
- Counters:
  - Saturate at 2^CNT_W−1; they do not wrap.
  - Update at the same edge as the event; a cycle may add 0..DEPTH to cnt_bubble.
  - Reset to 0.
- Reset mid-operation: all stages invalid and all counters 0 at the next edge, regardless of stall/flush. in_ready follows stall only, so it can be 1 during reset.
- All outputs except in_ready and retire are registered or direct register taps.

Decomposition:
- Shared package `pipe_pkg`:
  - Counter-width default.
  - Stage-index localparams for the 5-stage core: STG_D=0, STG_E=1, STG_M=2, STG_W=3.
  - Helper function computing the hold vector from stall.
- One natural sub-module, `pipe_stage_reg` (WIDTH, CLEAR_DATA): a single stage register with inputs load, bubble, flush and hold, instantiated DEPTH times in a generate loop.
- Counters stay in the top.

Test Plan (DEPTH=4, WIDTH=32, CLEAR_DATA=1, CNT_W=16):
1. Reset, then push 32'h11,22,33,44,55 on consecutive cycles with no stalls → out_data shows 11 on the 4th edge after the first push, then 22..55 on successive edges; cnt_retired=5 after draining; cnt_stall=0.
2. Stall stage 1 for 2 cycles with all stages full (A3..A0 oldest→youngest) → stages 0,1 hold; stage 2 becomes a bubble (valid=0, data=0) for 2 cycles; stage 3 retires normally; cnt_bubble +=2; cnt_stall +=2; in_ready=0 for those cycles.
3. Assert stall[0] and flush[1] together for 1 cycle (load-use) → stage 0 holds, stage 1 invalid and zero, stage 2 takes the old stage 1; cnt_bubble +=1.
4. Assert stall[3]=1 with a full chain → no stage changes, retire=0, cnt_retired unchanged; assert flush[3] as well → stage 3 clears and the others stay frozen.
5. Force cnt_retired near saturation (CNT_W=4 build, 20 retires) → cnt_retired stops at 15.
6. Assert reset mid-stream with stall[2]=1 and flush[0]=1 → next edge: stage_valid=0000, all stage_data=0, all counters=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline register chain: counter width
// default, stage indices of the 5-stage core and the hold-vector helper.
package pipe_pkg;

    localparam int CNT_W_DEFAULT = 16;

    // Stage indices of the 5-stage core when the chain is built with DEPTH=4.
    localparam int STG_D = 0;
    localparam int STG_E = 1;
    localparam int STG_M = 2;
    localparam int STG_W = 3;

    // Widest stall vector the hold helper understands.
    localparam int MAX_DEPTH = 32;

    // What a single stage register does at the next edge (reset aside).
    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_LOAD
    } stageAct_e;

    // Bit k of the hold vector: a stall anywhere at or downstream of stage k
    // freezes stage k. Callers evaluate it for each k to build the vector.
    function automatic logic holdBit(input logic [MAX_DEPTH-1:0] stallVec, input int k);
        logic acc;
        acc = 1'b0;
        for (int j = 0; j < MAX_DEPTH; j++) begin
            if (j >= k) begin
                acc = acc | stallVec[j];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/pipeline_chain_stage.sv
// One pipeline stage register: payload plus valid bit, with flush > hold >
// bubble > load priority below the synchronous reset.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             loadValid_i,
    input  logic [WIDTH-1:0] loadData_i,
    input  logic             bubble_i,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    stageAct_e        stageAct;
    logic             validD;
    logic             validQ;
    logic [WIDTH-1:0] dataD;
    logic [WIDTH-1:0] dataQ;

    // Pick the action for this edge; flush beats hold so a stalled stage can still be emptied.
    always_comb begin
        stageAct = ACT_LOAD;
        if (flush_i) begin
            stageAct = ACT_FLUSH;
        end else if (hold_i) begin
            stageAct = ACT_HOLD;
        end else if (bubble_i) begin
            stageAct = ACT_BUBBLE;
        end
    end

    // Next-state payload and valid for the chosen action.
    always_comb begin
        validD = validQ;
        dataD  = dataQ;
        case (stageAct)
            ACT_FLUSH, ACT_BUBBLE: begin
                validD = 1'b0;
                if (CLEAR_DATA) begin
                    dataD = '0;
                end
            end
            ACT_HOLD: begin
                validD = validQ;
                dataD  = dataQ;
            end
            ACT_LOAD: begin
                validD = loadValid_i;
                dataD  = loadData_i;
            end
            default: begin
                validD = validQ;
                dataD  = dataQ;
            end
        endcase
    end

    // Stage register with synchronous reset to an empty, zeroed stage.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            validQ <= 1'b0;
            dataQ  <= '0;
        end else begin
            validQ <= validD;
            dataQ  <= dataD;
        end
    end

    assign valid_o = validQ;
    assign data_o  = dataQ;

endmodule

// File: rtl/pipeline_chain.sv
// Generic in-order pipeline register chain: DEPTH stages with per-stage stall
// and flush, bubble insertion behind a stall and saturating event counters.
module pipeline_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic [DEPTH-1:0]       stall,
    input  logic [DEPTH-1:0]       flush,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*WIDTH-1:0] stage_data,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   retire,
    output logic [CNT_W-1:0]       cnt_retired,
    output logic [CNT_W-1:0]       cnt_stall,
    output logic [CNT_W-1:0]       cnt_bubble
);

    localparam int INC_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + INC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [MAX_DEPTH-1:0] stallWide;
    logic [DEPTH-1:0]     holdVec;
    logic [DEPTH-1:0]     validVec;
    logic [WIDTH-1:0]     dataArr [DEPTH];
    logic [DEPTH-1:0]     prevValid;
    logic [WIDTH-1:0]     prevData [DEPTH];
    logic [DEPTH-1:0]     bubbleVec;
    logic [INC_W-1:0]     bubbleInc;
    logic [CNT_W-1:0]     cntRetiredD, cntRetiredQ;
    logic [CNT_W-1:0]     cntStallD, cntStallQ;
    logic [CNT_W-1:0]     cntBubbleD, cntBubbleQ;

    // Saturating add of a small per-cycle increment onto a counter.
    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] cnt, input logic [INC_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cnt) + SUM_W'(inc);
        if (sum > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return sum[CNT_W-1:0];
    endfunction

    // Hold vector: stage k freezes when it or any older stage stalls.
    always_comb begin
        stallWide = MAX_DEPTH'(stall);
        holdVec   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            holdVec[k] = holdBit(stallWide, k);
        end
    end

    // Upstream source for each stage: in_* for stage 0, the younger neighbour otherwise.
    always_comb begin
        prevValid    = '0;
        bubbleVec    = '0;
        prevValid[0] = in_valid;
        prevData[0]  = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            prevValid[k] = validVec[k-1];
            prevData[k]  = dataArr[k-1];
            bubbleVec[k] = holdVec[k-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : gStage
        pipe_stage_reg #(
            .WIDTH      (WIDTH),
            .CLEAR_DATA (CLEAR_DATA)
        ) uStage (
            .clk_i       (clk),
            .reset_i     (reset),
            .loadValid_i (prevValid[g]),
            .loadData_i  (prevData[g]),
            .bubble_i    (bubbleVec[g]),
            .flush_i     (flush[g]),
            .hold_i      (holdVec[g]),
            .valid_o     (validVec[g]),
            .data_o      (dataArr[g])
        );
        assign stage_data[g*WIDTH +: WIDTH] = dataArr[g];
    end

    assign stage_valid = validVec;
    assign out_valid   = validVec[DEPTH-1];
    assign out_data    = dataArr[DEPTH-1];
    assign in_ready    = ~holdVec[0];
    assign retire      = validVec[DEPTH-1] & ~stall[DEPTH-1] & ~flush[DEPTH-1];

    // Count lost slots this cycle; a stage both bubbled and flushed counts once via the flush term.
    always_comb begin
        bubbleInc = '0;
        for (int k = 1; k < DEPTH; k++) begin
            if (holdVec[k-1] && !holdVec[k] && !flush[k]) begin
                bubbleInc = bubbleInc + INC_W'(1);
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (flush[k] && validVec[k]) begin
                bubbleInc = bubbleInc + INC_W'(1);
            end
        end
    end

    // Next counter values, each saturating rather than wrapping.
    always_comb begin
        cntRetiredD = satAdd(cntRetiredQ, INC_W'(retire));
        cntStallD   = satAdd(cntStallQ, INC_W'(holdVec[0]));
        cntBubbleD  = satAdd(cntBubbleQ, bubbleInc);
    end

    // Performance counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cntRetiredQ <= '0;
            cntStallQ   <= '0;
            cntBubbleQ  <= '0;
        end else begin
            cntRetiredQ <= cntRetiredD;
            cntStallQ   <= cntStallD;
            cntBubbleQ  <= cntBubbleD;
        end
    end

    assign cnt_retired = cntRetiredQ;
    assign cnt_stall   = cntStallQ;
    assign cnt_bubble  = cntBubbleQ;

endmodule

// File: tb/tb_pipeline_chain.sv
// Self-checking bench for pipeline_chain: a scoreboard queue checks the
// retiring stream while directed checks cover stage contents and counters.
module tb_pipeline_chain;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [31:0]  in_data;
    logic [3:0]   stall;
    logic [3:0]   flush;

    logic         in_ready;
    logic [3:0]   stage_valid;
    logic [127:0] stage_data;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         retire;
    logic [15:0]  cnt_retired;
    logic [15:0]  cnt_stall;
    logic [15:0]  cnt_bubble;

    logic         smallInReady;
    logic [3:0]   smallStageValid;
    logic [127:0] smallStageData;
    logic         smallOutValid;
    logic [31:0]  smallOutData;
    logic         smallRetire;
    logic [3:0]   smallCntRetired;
    logic [3:0]   smallCntStall;
    logic [3:0]   smallCntBubble;

    int           compareCount = 0;
    int           failCount    = 0;
    logic [31:0]  expQ [$];
    logic [31:0]  monExp;

    pipeline_chain #(.WIDTH(32), .DEPTH(4), .CLEAR_DATA(1'b1), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .stall       (stall),
        .flush       (flush),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .retire      (retire),
        .cnt_retired (cnt_retired),
        .cnt_stall   (cnt_stall),
        .cnt_bubble  (cnt_bubble)
    );

    pipeline_chain #(.WIDTH(32), .DEPTH(4), .CLEAR_DATA(1'b1), .CNT_W(4)) dutSmall (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (smallInReady),
        .stall       (stall),
        .flush       (flush),
        .stage_valid (smallStageValid),
        .stage_data  (smallStageData),
        .out_valid   (smallOutValid),
        .out_data    (smallOutData),
        .retire      (smallRetire),
        .cnt_retired (smallCntRetired),
        .cnt_stall   (smallCntStall),
        .cnt_bubble  (smallCntBubble)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pk(input logic [31:0] s3, input logic [31:0] s2,
                                        input logic [31:0] s1, input logic [31:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs and let the active edge consume them.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [3:0] st, input logic [3:0] fl);
        in_valid = v;
        in_data  = d;
        stall    = st;
        flush    = fl;
        tick();
    endtask

    // Monitor: every retirement must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && retire) begin
            compareCount++;
            if (expQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL retire_unexpected: got %0h, expected no retirement", out_data);
            end else begin
                monExp = expQ.pop_front();
                if (out_data !== monExp) begin
                    failCount++;
                    $display("[TB] FAIL retire_data: got %0h, expected %0h", out_data, monExp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        stall    = '0;
        flush    = '0;
        tick();
        tick();

        // Reset state
        checkOutput("rst_valid", 128'(stage_valid), 128'(4'b0000));
        checkOutput("rst_data", stage_data, 128'd0);
        checkOutput("rst_cnt_retired", 128'(cnt_retired), 128'd0);
        checkOutput("rst_cnt_bubble", 128'(cnt_bubble), 128'd0);
        checkOutput("rst_in_ready", 128'(in_ready), 128'd1);
        reset = 1'b0;

        // Test 1: five pushes with no stalls
        for (int i = 0; i < 5; i++) begin
            expQ.push_back(32'h11 * (i + 1));
            applyStimulus(1'b1, 32'h11 * (i + 1), 4'b0000, 4'b0000);
            if (i == 3) begin
                checkOutput("t1_out_valid", 128'(out_valid), 128'd1);
                checkOutput("t1_out_data", 128'(out_data), 128'h11);
            end
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 4'b0000, 4'b0000);
        checkOutput("t1_cnt_retired", 128'(cnt_retired), 128'd5);
        checkOutput("t1_cnt_stall", 128'(cnt_stall), 128'd0);
        checkOutput("t1_valid", 128'(stage_valid), 128'(4'b0000));

        // Test 2: stall stage 1 for two cycles with a full chain
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(32'hA3 - i);
            applyStimulus(1'b1, 32'hA3 - i, 4'b0000, 4'b0000);
        end
        checkOutput("t2_full_valid", 128'(stage_valid), 128'(4'b1111));
        checkOutput("t2_full_data", stage_data, pk(32'hA3, 32'hA2, 32'hA1, 32'hA0));
        applyStimulus(1'b0, 32'h0, 4'b0010, 4'b0000);
        checkOutput("t2_in_ready", 128'(in_ready), 128'd0);
        checkOutput("t2_c1_valid", 128'(stage_valid), 128'(4'b1011));
        checkOutput("t2_c1_data", stage_data, pk(32'hA2, 32'h0, 32'hA1, 32'hA0));
        applyStimulus(1'b0, 32'h0, 4'b0010, 4'b0000);
        checkOutput("t2_c2_valid", 128'(stage_valid), 128'(4'b0011));
        checkOutput("t2_c2_data", stage_data, pk(32'h0, 32'h0, 32'hA1, 32'hA0));
        checkOutput("t2_cnt_bubble", 128'(cnt_bubble), 128'd2);
        checkOutput("t2_cnt_stall", 128'(cnt_stall), 128'd2);
        checkOutput("t2_cnt_retired", 128'(cnt_retired), 128'd7);

        // Test 3: load-use, stall stage 0 and flush stage 1 together
        expQ.push_back(32'hC0);
        applyStimulus(1'b1, 32'hC0, 4'b0000, 4'b0000);
        checkOutput("t3_pre_valid", 128'(stage_valid), 128'(4'b0111));
        checkOutput("t3_pre_data", stage_data, pk(32'h0, 32'hA1, 32'hA0, 32'hC0));
        applyStimulus(1'b1, 32'hC1, 4'b0001, 4'b0010);
        checkOutput("t3_valid", 128'(stage_valid), 128'(4'b1101));
        checkOutput("t3_data", stage_data, pk(32'hA1, 32'hA0, 32'h0, 32'hC0));
        checkOutput("t3_cnt_bubble", 128'(cnt_bubble), 128'd3);
        checkOutput("t3_cnt_stall", 128'(cnt_stall), 128'd3);

        // Test 4: stall oldest stage, then flush it while stalled
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(32'hD0 + i);
            applyStimulus(1'b1, 32'hD0 + i, 4'b0000, 4'b0000);
        end
        checkOutput("t4_full_valid", 128'(stage_valid), 128'(4'b1111));
        checkOutput("t4_full_data", stage_data, pk(32'hC0, 32'hD0, 32'hD1, 32'hD2));
        checkOutput("t4_cnt_retired_pre", 128'(cnt_retired), 128'd9);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 4'b1000, 4'b0000);
            checkOutput("t4_retire", 128'(retire), 128'd0);
            checkOutput("t4_frozen_valid", 128'(stage_valid), 128'(4'b1111));
            checkOutput("t4_frozen_data", stage_data, pk(32'hC0, 32'hD0, 32'hD1, 32'hD2));
            checkOutput("t4_cnt_retired", 128'(cnt_retired), 128'd9);
        end
        void'(expQ.pop_front());
        applyStimulus(1'b0, 32'h0, 4'b1000, 4'b1000);
        checkOutput("t4_flush_valid", 128'(stage_valid), 128'(4'b0111));
        checkOutput("t4_flush_data", stage_data, pk(32'h0, 32'hD0, 32'hD1, 32'hD2));
        checkOutput("t4_cnt_bubble", 128'(cnt_bubble), 128'd4);
        checkOutput("t4_cnt_stall", 128'(cnt_stall), 128'd6);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 4'b0000, 4'b0000);
        checkOutput("t4_drain_retired", 128'(cnt_retired), 128'd12);
        checkOutput("t4_drain_valid", 128'(stage_valid), 128'(4'b0000));
        checkOutput("t4_sb_empty", 128'(expQ.size()), 128'd0);

        // Test 5: saturation of a 4-bit counter over 20 retirements
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 4'b0000, 4'b0000);
        reset = 1'b0;
        checkOutput("t5_small_rst", 128'(smallCntRetired), 128'd0);
        for (int i = 0; i < 20; i++) begin
            expQ.push_back(32'h100 + i);
            applyStimulus(1'b1, 32'h100 + i, 4'b0000, 4'b0000);
            if (i == 18) begin
                checkOutput("t5_main_15", 128'(cnt_retired), 128'd15);
                checkOutput("t5_small_15", 128'(smallCntRetired), 128'd15);
            end
            if (i == 19) begin
                checkOutput("t5_main_16", 128'(cnt_retired), 128'd16);
                checkOutput("t5_small_sat", 128'(smallCntRetired), 128'd15);
            end
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 4'b0000, 4'b0000);
        checkOutput("t5_main_20", 128'(cnt_retired), 128'd20);
        checkOutput("t5_small_final", 128'(smallCntRetired), 128'd15);

        // Test 6: reset mid-stream while stall and flush are asserted
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(32'hE0 + i);
            applyStimulus(1'b1, 32'hE0 + i, 4'b0000, 4'b0000);
        end
        checkOutput("t6_pre_valid", 128'(stage_valid), 128'(4'b0111));
        reset = 1'b1;
        applyStimulus(1'b1, 32'hE3, 4'b0100, 4'b0001);
        expQ.delete();
        checkOutput("t6_in_ready", 128'(in_ready), 128'd0);
        checkOutput("t6_valid", 128'(stage_valid), 128'(4'b0000));
        checkOutput("t6_data", stage_data, 128'd0);
        checkOutput("t6_cnt_retired", 128'(cnt_retired), 128'd0);
        checkOutput("t6_cnt_stall", 128'(cnt_stall), 128'd0);
        checkOutput("t6_cnt_bubble", 128'(cnt_bubble), 128'd0);
        checkOutput("t6_small_retired", 128'(smallCntRetired), 128'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 4'b0000, 4'b0000);
        checkOutput("final_sb_empty", 128'(expQ.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
